// File: rtl/nonrestoring_div.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// followed by one remainder-correction cycle. Results are held until the next load.
module nonrestoring_div #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                  state_q;
  logic signed [WIDTH:0]   acc_q;
  logic signed [WIDTH:0]   acc_d;
  logic [WIDTH-1:0]        q_q;
  logic [WIDTH-1:0]        q_d;
  logic [WIDTH-1:0]        m_q;
  logic [WIDTH-1:0]        qout_q;
  logic [WIDTH-1:0]        r_q;
  logic [WIDTH-1:0]        r_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    done_q;

  // One non-restoring step: shift the next dividend bit in, then subtract M
  // when the accumulator was non-negative, otherwise add it back.
  function automatic logic signed [WIDTH:0] nr_step(
    input logic signed [WIDTH:0] acc,
    input logic                  q_msb,
    input logic [WIDTH-1:0]      m
  );
    logic signed [WIDTH:0] shifted;
    logic signed [WIDTH:0] m_ext;
    shifted = {acc[WIDTH-1:0], q_msb};
    m_ext   = {1'b0, m};
    return acc[WIDTH] ? (shifted + m_ext) : (shifted - m_ext);
  endfunction

  // The final remainder lies in [0, M), so the correction can be done
  // modulo 2^WIDTH and the sign bit dropped.
  function automatic logic [WIDTH-1:0] fix_rem(
    input logic signed [WIDTH:0] acc,
    input logic [WIDTH-1:0]      m
  );
    return acc[WIDTH-1:0] + (acc[WIDTH] ? m : '0);
  endfunction

  always_comb begin
    acc_d = nr_step(acc_q, q_q[WIDTH-1], m_q);
    q_d   = {q_q[WIDTH-2:0], ~acc_d[WIDTH]};
    r_d   = fix_rem(acc_q, m_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= Q;
            m_q     <= M;
            acc_q   <= {1'b0, A};
            cnt_q   <= CNT_W'(WIDTH);
            done_q  <= 1'b0;
            state_q <= ITER;
          end
        end
        ITER: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FINAL;
        end
        FINAL: begin
          qout_q  <= q_q;
          r_q     <= r_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          // A start held high must not launch a second division.
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q_out = qout_q;
  assign R     = r_q;
  assign done  = done_q;

endmodule

// File: tb/tb_nonrestoring_div.sv
// Directed bench for nonrestoring_div: an 8-bit and a 512-bit instance on one clock.
module tb_nonrestoring_div;

  localparam int W8   = 8;
  localparam int W512 = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic            start8 = 1'b0;
  logic [W8-1:0]   Q8 = '0, M8 = '0, A8 = '0;
  logic [W8-1:0]   Qo8, R8;
  logic            done8;

  logic            start512 = 1'b0;
  logic [W512-1:0] Q512 = '0, M512 = '0, A512 = '0;
  logic [W512-1:0] Qo512, R512;
  logic            done512;

  int checks = 0;
  int errors = 0;

  nonrestoring_div #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .Q(Q8), .M(M8), .A(A8),
    .Q_out(Qo8), .R(R8), .done(done8)
  );

  nonrestoring_div #(.WIDTH(W512)) dut512 (
    .clk(clk), .rst(rst), .start(start512), .Q(Q512), .M(M512), .A(A512),
    .Q_out(Qo512), .R(R512), .done(done512)
  );

  function automatic logic [W512-1:0] rnd512();
    logic [W512-1:0] r;
    for (int i = 0; i < W512 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do8(input logic [W8-1:0] q, input logic [W8-1:0] m,
                     input logic [W8-1:0] a, output int lat);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); Q8 = q; M8 = m; A8 = a; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic do512(input logic [W512-1:0] q, input logic [W512-1:0] m,
                       input bit chg, output int lat);
    @(negedge clk); start512 = 1'b0;
    @(negedge clk); Q512 = q; M512 = m; A512 = '0; start512 = 1'b1;
    @(posedge clk);
    @(negedge clk); start512 = 1'b0;
    lat = 0;
    while (!done512 && lat < 1000) begin
      @(posedge clk); lat++; @(negedge clk);
      if (chg && lat == 50) begin
        Q512 = rnd512(); M512 = rnd512(); A512 = rnd512();
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Qo8 !== 8'd0 || R8 !== 8'd0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8 got q=%0d r=%0d done=%b exp 0 0 0", Qo8, R8, done8);
    end
    checks++;
    if (Qo512 !== '0 || R512 !== '0 || done512 !== 1'b0) begin
      errors++;
      $display("FAIL reset512 got done=%b q_nonzero=%b r_nonzero=%b exp all zero",
               done512, |Qo512, |R512);
    end
    rst = 1'b0;
  endtask

  task automatic test_div8();
    int lat;
    logic [W8-1:0] vq[6] = '{8'd100, 8'd3,  8'd255, 8'd255, 8'd0, 8'd200};
    logic [W8-1:0] vm[6] = '{8'd7,   8'd10, 8'd1,   8'd255, 8'd3, 8'd0};
    logic [W8-1:0] va[6] = '{8'd0,   8'd0,  8'd0,   8'd0,   8'd1, 8'd0};
    // 100/7=14r2; 3/10=0r3; 255/1; 255/255; (1*256+0)/3=85r1;
    // divide by zero returns all-ones with the dividend as remainder
    logic [W8-1:0] eq[6] = '{8'd14, 8'd0, 8'd255, 8'd1, 8'd85, 8'd255};
    logic [W8-1:0] er[6] = '{8'd2,  8'd3, 8'd0,   8'd0, 8'd1,  8'd200};
    for (int i = 0; i < 6; i++) begin
      do8(vq[i], vm[i], va[i], lat);
      checks++;
      if (lat !== W8 + 1) begin
        errors++;
        $display("FAIL lat8[%0d] got %0d exp %0d", i, lat, W8 + 1);
      end
      checks++;
      if (Qo8 !== eq[i] || R8 !== er[i]) begin
        errors++;
        $display("FAIL div8[%0d] got q=%0d r=%0d exp q=%0d r=%0d",
                 i, Qo8, R8, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    do8(8'd100, 8'd7, 8'd0, lat);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); Q8 = 8'd3; M8 = 8'd10; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0 || Qo8 !== 8'd14 || R8 !== 8'd2) begin
      errors++;
      $display("FAIL hold8 got done=%b q=%0d r=%0d exp done=0 q=14 r=2", done8, Qo8, R8);
    end
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat !== W8 + 1 || Qo8 !== 8'd0 || R8 !== 8'd3) begin
      errors++;
      $display("FAIL hold8_next got lat=%0d q=%0d r=%0d exp lat=9 q=0 r=3", lat, Qo8, R8);
    end
  endtask

  task automatic test_held_start();
    int lat;
    bit dropped;
    logic [W512-1:0] exp_q;
    exp_q = {256{2'b01}};
    @(negedge clk); start512 = 1'b0;
    @(negedge clk); Q512 = '1; M512 = 512'd3; A512 = '0; start512 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!done512 && lat < 1000) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat !== W512 + 1) begin
      errors++;
      $display("FAIL held_lat got %0d exp %0d", lat, W512 + 1);
    end
    checks++;
    if (Qo512 !== exp_q || R512 !== '0) begin
      errors++;
      $display("FAIL held_res got q=%0h r=%0h", Qo512, R512);
    end
    Q512 = 512'd77; M512 = 512'd5;
    dropped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); @(negedge clk);
      if (done512 !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped || Qo512 !== exp_q || R512 !== '0) begin
      errors++;
      $display("FAIL held_once got dropped=%b q_changed=%b exp no restart",
               dropped, Qo512 !== exp_q);
    end
    start512 = 1'b0;
  endtask

  task automatic test_small512();
    int lat;
    do512(512'd5, 512'd9, 1'b0, lat);
    checks++;
    if (lat !== W512 + 1 || Qo512 !== 512'd0 || R512 !== 512'd5) begin
      errors++;
      $display("FAIL small_5_9 got lat=%0d q=%0h r=%0h exp lat=513 q=0 r=5", lat, Qo512, R512);
    end
    do512(512'd9, 512'd1, 1'b0, lat);
    checks++;
    if (lat !== W512 + 1 || Qo512 !== 512'd9 || R512 !== 512'd0) begin
      errors++;
      $display("FAIL small_9_1 got lat=%0d q=%0h r=%0h exp lat=513 q=9 r=0", lat, Qo512, R512);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk); start512 = 1'b0;
    @(negedge clk); Q512 = rnd512(); M512 = 512'd12345; start512 = 1'b1;
    @(posedge clk);
    @(negedge clk); start512 = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    checks++;
    if (Qo512 !== '0 || R512 !== '0 || done512 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got done=%b q_nonzero=%b r_nonzero=%b exp all zero",
               done512, |Qo512, |R512);
    end
    // Nothing may surface from the aborted division.
    lat = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); @(negedge clk);
      if (done512) lat++;
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL reset_abort got done_cycles=%0d exp 0", lat);
    end
    do512(512'd1000, 512'd33, 1'b0, lat);
    checks++;
    if (lat !== W512 + 1 || Qo512 !== 512'd30 || R512 !== 512'd10) begin
      errors++;
      $display("FAIL reset_after got lat=%0d q=%0h r=%0h exp lat=513 q=30 r=10", lat, Qo512, R512);
    end
  endtask

  task automatic test_random512();
    int lat;
    logic [W512-1:0] q, m, eq, er;
    logic [2*W512-1:0] recon;
    for (int i = 0; i < 8; i++) begin
      q = rnd512();
      m = rnd512() >> $urandom_range(0, 500);
      if (m == '0) m = 512'd1;
      eq = q / m;
      er = q % m;
      do512(q, m, (i % 2) == 1, lat);
      checks++;
      if (lat !== W512 + 1 || Qo512 !== eq || R512 !== er) begin
        errors++;
        $display("FAIL rand[%0d] lat=%0d q_ok=%b r_ok=%b got r=%0h exp r=%0h",
                 i, lat, Qo512 === eq, R512 === er, R512, er);
      end
      recon = {{W512{1'b0}}, Qo512} * {{W512{1'b0}}, m} + {{W512{1'b0}}, R512};
      checks++;
      if (recon !== {{W512{1'b0}}, q} || !(R512 < m)) begin
        errors++;
        $display("FAIL invariant[%0d] recon_ok=%b r_lt_m=%b", i,
                 recon === {{W512{1'b0}}, q}, R512 < m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div8();
    test_hold();
    test_held_start();
    test_small512();
    test_reset_mid();
    test_random512();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
